// File: rtl/hangman_guess_ctrl_pkg.sv
// Shared definitions for the Hangman guess controller slice.
//   game_state_e : encoding of current_state reported by game_status
//   LETTER_W     : bits per letter code (A=0 .. Z=25)
//   NUM_LETTERS  : size of the alphabet / used-letter mask
package hangman_guess_ctrl_pkg;

  typedef enum logic [1:0] {
    GS_START    = 2'd0,
    GS_INGAME   = 2'd1,
    GS_WINGAME  = 2'd2,
    GS_LOSTGAME = 2'd3
  } game_state_e;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

endpackage

// File: rtl/hangman_guess_ctrl_if.sv
// Guess handshake between the keyboard/letter decoder (master) and the
// guess controller (slave).
//   guess_valid  : letter offered by the decoder
//   guess_letter : offered letter code
//   guess_ready  : controller accepts a guess this cycle
//   hit/miss/dup : single-cycle outcome pulses for an offered guess
interface hangman_guess_ctrl_if;
  import hangman_guess_ctrl_pkg::*;

  logic                guess_valid;
  logic [LETTER_W-1:0] guess_letter;
  logic                guess_ready;
  logic                hit;
  logic                miss;
  logic                dup;

  modport master (
    output guess_valid, guess_letter,
    input  guess_ready, hit, miss, dup
  );

  modport slave (
    input  guess_valid, guess_letter,
    output guess_ready, hit, miss, dup
  );
endinterface

// File: rtl/hangman_guess_ctrl_letter_scan.sv
// letter_scan: walks the secret word one position per cycle comparing it
// against a latched guess letter.
//   clk, reset : clock, asynchronous active-low reset
//   start      : latch letter_in, clear match, begin at index 0
//   cancel     : abandon a scan in progress
//   letter_in  : guess letter to latch on start
//   letters    : secret word, one letter per position
//   len        : number of active positions (already clamped)
//   idx        : position compared in the current cycle
//   pos_hit    : current position is active and matches
//   done       : current cycle compares the last position
//   match      : at least one active position has matched so far
module letter_scan
  import hangman_guess_ctrl_pkg::*;
#(
  parameter int WORD_LEN = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      cancel,
  input  logic [LETTER_W-1:0]                       letter_in,
  input  logic [WORD_LEN-1:0][LETTER_W-1:0]         letters,
  input  logic [$clog2(WORD_LEN+1)-1:0]             len,
  output logic [((WORD_LEN > 1) ? $clog2(WORD_LEN) : 1)-1:0] idx,
  output logic                                      pos_hit,
  output logic                                      done,
  output logic                                      match
);
  localparam int LENW = $clog2(WORD_LEN+1);
  localparam int IW   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  logic                busy;
  logic [LETTER_W-1:0] letter_q;

  // Positions at or beyond len are never compared as matches.
  assign pos_hit = busy && (LENW'(idx) < len) && (letters[idx] == letter_q);
  assign done    = busy && (idx == IW'(WORD_LEN-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      idx      <= '0;
      match    <= 1'b0;
      letter_q <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      idx      <= '0;
      match    <= 1'b0;
      letter_q <= letter_in;
    end else if (cancel) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (pos_hit) match <= 1'b1;
      if (done) busy <= 1'b0;
      else      idx  <= idx + IW'(1);
    end
  end
endmodule

// File: rtl/hangman_guess_ctrl.sv
// hangman_guess_ctrl: sequences one Hangman round while game_status is INGAME.
//   clk, reset    : clock, asynchronous active-low reset
//   game_state    : current_state from game_status
//   word          : secret word, letter i at [5i+4:5i]
//   word_len      : active letters (0 or > WORD_LEN means WORD_LEN)
//   guess         : guess handshake and hit/miss/dup pulses (slave side)
//   revealed_mask : bit i set = position i shown
//   used_letters  : bit k set = letter k already guessed
//   lives_left    : remaining lives
//   win_game      : 1-cycle pulse, every position revealed
//   lost_game     : 1-cycle pulse, last life spent
module hangman_guess_ctrl
  import hangman_guess_ctrl_pkg::*;
#(
  parameter int WORD_LEN  = 8,
  parameter int MAX_LIVES = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [1:0]                         game_state,
  input  logic [LETTER_W*WORD_LEN-1:0]       word,
  input  logic [$clog2(WORD_LEN+1)-1:0]      word_len,
  hangman_guess_ctrl_if.slave                guess,
  output logic [WORD_LEN-1:0]                revealed_mask,
  output logic [NUM_LETTERS-1:0]             used_letters,
  output logic [$clog2(MAX_LIVES+1)-1:0]     lives_left,
  output logic                               win_game,
  output logic                               lost_game
);
  localparam int LENW = $clog2(WORD_LEN+1);
  localparam int LW   = $clog2(MAX_LIVES+1);
  localparam int IW   = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_JUDGE, S_END} state_e;
  state_e state, state_next;

  logic [WORD_LEN-1:0][LETTER_W-1:0] letters;
  logic [LENW-1:0]     len_q, len_clamped;
  logic [WORD_LEN-1:0] reveal_init;
  logic [LW-1:0]       lives_dec;
  logic [IW-1:0]       scan_idx;
  logic ingame, accept, dup_set, scan_cancel;
  logic scan_hit, scan_done, scan_match;
  logic judge_win, judge_lost;

  assign ingame      = (game_state == GS_INGAME);
  assign scan_cancel = (state == S_SCAN) && !ingame;
  assign lives_dec   = (lives_left == '0) ? '0 : lives_left - LW'(1);
  // A win needs a hit, a loss needs a miss, so the two never coincide.
  assign judge_win   = scan_match && (&revealed_mask);
  assign judge_lost  = !scan_match && (lives_dec == '0);

  always_comb begin
    len_clamped = word_len;
    if (word_len == '0 || word_len > LENW'(WORD_LEN)) len_clamped = LENW'(WORD_LEN);
    reveal_init = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++)
      reveal_init[i] = (LENW'(i) >= len_clamped);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    dup_set    = 1'b0;
    unique case (state)
      S_IDLE: if (ingame) state_next = S_WAIT;
      S_WAIT: begin
        if (!ingame) begin
          state_next = S_IDLE;
        end else if (guess.guess_valid && guess.guess_letter < LETTER_W'(NUM_LETTERS)) begin
          if (used_letters[guess.guess_letter]) begin
            dup_set = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (!ingame)        state_next = S_IDLE;
        else if (scan_done) state_next = S_JUDGE;
      end
      S_JUDGE: begin
        if (!ingame)                     state_next = S_IDLE;
        else if (judge_win || judge_lost) state_next = S_END;
        else                             state_next = S_WAIT;
      end
      S_END: if (!ingame) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  letter_scan #(.WORD_LEN(WORD_LEN)) u_scan (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .cancel    (scan_cancel),
    .letter_in (guess.guess_letter),
    .letters   (letters),
    .len       (len_q),
    .idx       (scan_idx),
    .pos_hit   (scan_hit),
    .done      (scan_done),
    .match     (scan_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      letters           <= '0;
      len_q             <= '0;
      revealed_mask     <= '0;
      used_letters      <= '0;
      lives_left        <= '0;
      guess.guess_ready <= 1'b0;
      guess.hit         <= 1'b0;
      guess.miss        <= 1'b0;
      guess.dup         <= 1'b0;
      win_game          <= 1'b0;
      lost_game         <= 1'b0;
    end else begin
      state             <= state_next;
      // Registered so guess_ready has no path from the guess inputs.
      guess.guess_ready <= (state_next == S_WAIT);
      guess.hit         <= 1'b0;
      guess.miss        <= 1'b0;
      guess.dup         <= dup_set;
      win_game          <= 1'b0;
      lost_game         <= 1'b0;

      if (state == S_IDLE && ingame) begin
        for (int unsigned i = 0; i < WORD_LEN; i++)
          letters[i] <= word[LETTER_W*i +: LETTER_W];
        len_q         <= len_clamped;
        used_letters  <= '0;
        revealed_mask <= reveal_init;
        lives_left    <= LW'(MAX_LIVES);
      end

      if (accept) used_letters[guess.guess_letter] <= 1'b1;

      if (state == S_SCAN && ingame && scan_hit) revealed_mask[scan_idx] <= 1'b1;

      if (state == S_JUDGE && ingame) begin
        guess.hit  <= scan_match;
        guess.miss <= !scan_match;
        if (!scan_match) lives_left <= lives_dec;
        win_game   <= judge_win;
        lost_game  <= judge_lost;
      end
    end
  end
endmodule

// File: tb/tb_hangman_guess_ctrl.sv
module tb_hangman_guess_ctrl;
  import hangman_guess_ctrl_pkg::*;

  localparam int WL = 4;
  localparam int ML = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  game_state;
  logic [19:0] word;
  logic [2:0]  word_len;
  logic [3:0]  revealed_mask;
  logic [25:0] used_letters;
  logic [1:0]  lives_left;
  logic        win_game, lost_game;

  hangman_guess_ctrl_if gif();

  hangman_guess_ctrl #(.WORD_LEN(WL), .MAX_LIVES(ML)) dut (
    .clk           (clk),
    .reset         (reset),
    .game_state    (game_state),
    .word          (word),
    .word_len      (word_len),
    .guess         (gif),
    .revealed_mask (revealed_mask),
    .used_letters  (used_letters),
    .lives_left    (lives_left),
    .win_game      (win_game),
    .lost_game     (lost_game)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_used;

  // pulse: {hit, miss, dup} expected at cycle lat after the guess cycle
  typedef struct {
    logic [4:0] letter;
    logic [2:0] pulse;
    int         lat;
    logic       win;
    logic       lost;
    logic [3:0] mask;
    logic [1:0] lives;
    logic       ready;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int n);
    vec_t v;
    int   w, first, npulse;
    logic [2:0] kind;
    logic winv, lostv;
    v = vecs[n];
    w = 0;
    while (gif.guess_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d_ready_pre", n), {31'd0, gif.guess_ready}, 32'd1);
    gif.guess_valid  = 1'b1;
    gif.guess_letter = v.letter;
    first = 0; npulse = 0; kind = '0; winv = 1'b0; lostv = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) gif.guess_valid = 1'b0;
      if (gif.hit || gif.miss || gif.dup || win_game || lost_game) begin
        npulse++;
        if (first == 0) begin
          first = k;
          kind  = {gif.hit, gif.miss, gif.dup};
          winv  = win_game;
          lostv = lost_game;
        end
      end
    end
    if (v.letter < 5'd26) exp_used[v.letter] = 1'b1;
    check($sformatf("v%0d_latency", n), first, v.lat);
    check($sformatf("v%0d_kind", n), {29'd0, kind}, {29'd0, v.pulse});
    check($sformatf("v%0d_win", n), {31'd0, winv}, {31'd0, v.win});
    check($sformatf("v%0d_lost", n), {31'd0, lostv}, {31'd0, v.lost});
    check($sformatf("v%0d_npulse", n), npulse, (v.pulse != 3'b000) ? 1 : 0);
    check($sformatf("v%0d_mask", n), {28'd0, revealed_mask}, {28'd0, v.mask});
    check($sformatf("v%0d_lives", n), {30'd0, lives_left}, {30'd0, v.lives});
    check($sformatf("v%0d_ready", n), {31'd0, gif.guess_ready}, {31'd0, v.ready});
    check($sformatf("v%0d_used", n), {6'd0, used_letters}, {6'd0, exp_used});
  endtask

  task automatic check_round_start(input string tag, input logic [3:0] mask);
    check({tag, "_mask"}, {28'd0, revealed_mask}, {28'd0, mask});
    check({tag, "_lives"}, {30'd0, lives_left}, 32'd3);
    check({tag, "_ready"}, {31'd0, gif.guess_ready}, 32'd1);
    check({tag, "_used"}, {6'd0, used_letters}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{5'd0,  3'b100, 6, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1}; // A hit
    vecs[1]  = '{5'd0,  3'b001, 1, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1}; // A dup
    vecs[2]  = '{5'd27, 3'b000, 0, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1}; // dropped
    vecs[3]  = '{5'd2,  3'b100, 6, 1'b0, 1'b0, 4'b1011, 2'd3, 1'b1}; // C hit
    vecs[4]  = '{5'd19, 3'b100, 6, 1'b1, 1'b0, 4'b1111, 2'd3, 1'b0}; // T hit+win
    vecs[5]  = '{5'd25, 3'b010, 6, 1'b0, 1'b0, 4'b1000, 2'd2, 1'b1}; // Z miss
    vecs[6]  = '{5'd16, 3'b010, 6, 1'b0, 1'b0, 4'b1000, 2'd1, 1'b1}; // Q miss
    vecs[7]  = '{5'd23, 3'b010, 6, 1'b0, 1'b1, 4'b1000, 2'd0, 1'b0}; // X miss+lost
    vecs[8]  = '{5'd4,  3'b100, 6, 1'b0, 1'b0, 4'b0110, 2'd3, 1'b1}; // E twice
    vecs[9]  = '{5'd5,  3'b100, 6, 1'b0, 1'b0, 4'b1110, 2'd3, 1'b1}; // F at pos3
    vecs[10] = '{5'd4,  3'b001, 1, 1'b0, 1'b0, 4'b1110, 2'd3, 1'b1}; // E dup
    vecs[11] = '{5'd26, 3'b000, 0, 1'b0, 1'b0, 4'b1110, 2'd3, 1'b1}; // dropped

    game_state       = 2'd0;
    word             = {5'd0, 5'd19, 5'd0, 5'd2};   // "CAT", pos3 inactive
    word_len         = 3'd3;
    gif.guess_valid  = 1'b0;
    gif.guess_letter = 5'd0;
    exp_used         = '0;

    repeat (2) @(negedge clk);
    check("rst_mask", {28'd0, revealed_mask}, 32'd0);
    check("rst_used", {6'd0, used_letters}, 32'd0);
    check("rst_lives", {30'd0, lives_left}, 32'd0);
    check("rst_ready", {31'd0, gif.guess_ready}, 32'd0);
    check("rst_pulses", {27'd0, gif.hit, gif.miss, gif.dup, win_game, lost_game}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, gif.guess_ready}, 32'd0);

    // Round 1: CAT, win
    game_state = 2'd1;
    @(negedge clk);
    check_round_start("r1", 4'b1000);
    for (int i = 0; i <= 4; i++) apply(i);
    game_state = 2'd2;
    @(negedge clk);
    check("r1_end_ready", {31'd0, gif.guess_ready}, 32'd0);
    check("r1_end_mask", {28'd0, revealed_mask}, 32'hF);

    // Round 2: CAT, lose
    game_state = 2'd1;
    exp_used   = '0;
    @(negedge clk);
    check_round_start("r2", 4'b1000);
    for (int i = 5; i <= 7; i++) apply(i);
    repeat (3) @(negedge clk);
    check("r2_end_ready", {31'd0, gif.guess_ready}, 32'd0);
    check("r2_end_lives", {30'd0, lives_left}, 32'd0);

    // Round 3: BEEF with word_len 0 (all four positions active)
    game_state = 2'd0;
    @(negedge clk);
    word       = {5'd5, 5'd4, 5'd4, 5'd1};
    word_len   = 3'd0;
    game_state = 2'd1;
    exp_used   = '0;
    @(negedge clk);
    check_round_start("r3", 4'b0000);
    for (int i = 8; i <= 11; i++) apply(i);

    // Abort mid-scan with a non-matching G
    begin
      int np;
      np = 0;
      gif.guess_valid  = 1'b1;
      gif.guess_letter = 5'd6;
      @(negedge clk);
      gif.guess_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      game_state = 2'd0;
      exp_used[6] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (gif.hit || gif.miss || gif.dup || win_game || lost_game) np++;
      end
      check("abort_pulses", np, 0);
      check("abort_ready", {31'd0, gif.guess_ready}, 32'd0);
      check("abort_mask", {28'd0, revealed_mask}, 32'hE);
      check("abort_lives", {30'd0, lives_left}, 32'd3);
      check("abort_used", {6'd0, used_letters}, {6'd0, exp_used});
    end
    game_state = 2'd1;
    exp_used   = '0;
    @(negedge clk);
    check_round_start("r4", 4'b0000);

    // Asynchronous reset during a scan
    gif.guess_valid  = 1'b1;
    gif.guess_letter = 5'd0;
    @(negedge clk);
    gif.guess_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_mask", {28'd0, revealed_mask}, 32'd0);
    check("arst_used", {6'd0, used_letters}, 32'd0);
    check("arst_lives", {30'd0, lives_left}, 32'd0);
    check("arst_ready", {31'd0, gif.guess_ready}, 32'd0);
    check("arst_pulses", {27'd0, gif.hit, gif.miss, gif.dup, win_game, lost_game}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
